button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/tl_pkg.sv | 12 +
 rtl/btn_sync.sv | 23 ++
 rtl/button_conditioner.sv | 106 ++++++++++
 tb/tb_button_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light types: the debounce state encoding is used by the
// button conditioner, the sequencer and the benches.
package tl_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser for the asynchronous button input.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect the pedestrian button, then hold a
// sticky request until the consumer acknowledges it.
module button_conditioner
    import tl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic ack,
    output logic b,
    output logic press,
    output logic req,
    output logic overrun
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;

    btn_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (w_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= LOW;
            r_cnt   <= '0;
            b       <= 1'b0;
            press   <= 1'b0;
            req     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            press <= 1'b0;
            case (r_state)
                LOW: begin
                    if (w_s) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!w_s) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        b       <= 1'b1;
                        press   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    // A bounce back high returns to HIGH without a new press.
                    if (w_s) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        b       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                    b       <= 1'b0;
                end
            endcase

            // A press landing on top of an ack keeps the request without flagging overrun.
            if (press) begin
                req <= 1'b1;
            end else if (ack) begin
                req <= 1'b0;
            end

            if (press && req && !ack) begin
                overrun <= 1'b1;
            end else if (ack) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a run-length reference model pushes expected
// outputs per cycle into a queue, popped and compared after each clock edge.
module tb_button_conditioner;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic ack = 1'b0;
    logic b, press, req, overrun;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [1:0] m_sync = 2'b00;
    logic       m_runval = 1'b0;
    int         m_run = 0;
    logic       m_b = 1'b0, m_press = 1'b0, m_req = 1'b0, m_ovr = 1'b0;
    logic [3:0] exp_q[$];
    string      cur_tag = "init";

    button_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .ack     (ack),
        .b       (b),
        .press   (press),
        .req     (req),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model one clock edge: b follows s once s has held a new value for DEB samples.
    task automatic model_edge(input logic raw, input logic a, input logic rs);
        logic s, nb, np, nr, no;
        if (!rs) begin
            m_sync = 2'b00; m_runval = 1'b0; m_run = 0;
            m_b = 1'b0; m_press = 1'b0; m_req = 1'b0; m_ovr = 1'b0;
        end else begin
            s = m_sync[1];
            if (s == m_runval) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_runval = s;
                m_run    = 1;
            end
            nb = (m_run >= DEB && m_runval != m_b) ? m_runval : m_b;
            np = nb & ~m_b;
            nr = m_press ? 1'b1 : (a ? 1'b0 : m_req);
            no = (m_press && m_req && !a) ? 1'b1 : (a ? 1'b0 : m_ovr);
            m_b = nb; m_press = np; m_req = nr; m_ovr = no;
            m_sync = {m_sync[0], raw};
        end
        exp_q.push_back({m_b, m_press, m_req, m_ovr});
    endtask

    task automatic tick(input logic raw, input logic a, input logic rs);
        logic [3:0] e;
        btn_raw = raw;
        ack     = a;
        rst     = rs;
        model_edge(raw, a, rs);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({cur_tag, ".b"},       {31'd0, b},       {31'd0, e[3]});
        chk({cur_tag, ".press"},   {31'd0, press},   {31'd0, e[2]});
        chk({cur_tag, ".req"},     {31'd0, req},     {31'd0, e[1]});
        chk({cur_tag, ".overrun"}, {31'd0, overrun}, {31'd0, e[0]});
    endtask

    // Hold raw until b reaches target; returns cycles taken (bounded).
    task automatic hold_until_b(input logic raw, input logic target, output int n);
        bit done;
        done = 0;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick(raw, 1'b0, 1'b1);
            n++;
            if (b === target) done = 1;
        end
        if (!done) n = -1;
    endtask

    task automatic idle(input logic raw, input int cycles);
        for (int i = 0; i < cycles; i++) tick(raw, 1'b0, 1'b1);
    endtask

    initial begin
        int lat;
        int pw;

        cur_tag = "reset_hold";
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        hold_until_b(1'b1, 1'b1, lat);
        chk("reset_release_latency", lat, 6);
        chk("reset_press_pulse", {31'd0, press}, 1);
        tick(1'b1, 1'b0, 1'b1);
        chk("reset_req_next", {31'd0, req}, 1);
        tick(1'b0, 1'b1, 1'b1);
        idle(1'b0, 10);

        cur_tag = "bounce";
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b1);
        idle(1'b0, 10);
        chk("bounce_req", {31'd0, req}, 0);

        cur_tag = "clean";
        hold_until_b(1'b1, 1'b1, lat);
        chk("clean_latency", lat, 6);
        pw = 0;
        if (press === 1'b1) pw++;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (press === 1'b1) pw++;
        end
        chk("clean_press_width", pw, 1);
        chk("clean_req_held", {31'd0, req}, 1);
        tick(1'b1, 1'b1, 1'b1);
        chk("clean_req_cleared", {31'd0, req}, 0);

        cur_tag = "release_bounce";
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        hold_until_b(1'b0, 1'b0, lat);
        chk("release_latency", lat, 6);
        idle(1'b0, 6);
        chk("release_no_req", {31'd0, req}, 0);

        cur_tag = "overrun";
        idle(1'b1, 10);
        idle(1'b0, 10);
        idle(1'b1, 10);
        chk("overrun_set", {31'd0, overrun}, 1);
        tick(1'b1, 1'b1, 1'b1);
        chk("overrun_ack_req", {31'd0, req}, 0);
        chk("overrun_ack_ovr", {31'd0, overrun}, 0);
        idle(1'b0, 10);

        cur_tag = "collision";
        idle(1'b1, 10);
        idle(1'b0, 10);
        for (int i = 0; i < 12; i++) tick(1'b1, m_press, 1'b1);
        chk("collision_req", {31'd0, req}, 1);
        chk("collision_ovr", {31'd0, overrun}, 0);
        tick(1'b1, 1'b1, 1'b1);
        idle(1'b0, 10);

        cur_tag = "random";
        begin
            logic r;
            int   run;
            r = 1'b0;
            run = 0;
            for (int i = 0; i < 600; i++) begin
                if (run == 0) begin
                    r   = ~r;
                    run = $urandom_range(1, 9);
                end
                run--;
                tick(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
